lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store responder at the far end of the EX/MEM pipeline register.
//  Consumes memread/memwrite/length/sign/result/data2 and runs a req/ack access on the data-memory bus.
//  Stalls the pipeline while the access is in flight and returns aligned, extended load data to MEM/WB rdata.
//  Also reports misaligned accesses and bus timeouts.
// PARAMETERS
//  ADDR_W   12  byte address width (matches 12-bit PC/result path)
//  DATA_W   32  data width; fixed at 32, 4 byte lanes
//  TIMEOUT  15  max cycles in BUSY waiting for bus_ack before error
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous, active-low reset
//  memread    in   1       load request (EX/MEM memreadout)
//  memwrite   in   1       store request (EX/MEM memwriteout)
//  length     in   2       00 byte, 01 half, 10/11 word
//  sign       in   1       1 = sign-extend load, 0 = zero-extend
//  addr       in   ADDR_W  byte address (EX/MEM resultout[ADDR_W-1:0])
//  wdata      in   32      store data (EX/MEM data2out)
//  rdata      out  32      extended load data to MEM/WB
//  stall      out  1       1 = hold PC, IF/ID and EX/MEM (drives pcwrite/fdwrite low)
//  misalign   out  1       1-cycle pulse: misaligned access dropped
//  err        out  1       1-cycle pulse: bus timeout
//  bus_req    out  1       bus request, held until ack
//  bus_we     out  1       1 = write
//  bus_addr   out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
//  bus_be     out  4       byte enables
//  bus_wdata  out  32      lane-replicated store data
//  bus_ack    in   1       1-cycle access complete
//  bus_rdata  in   32      read word, valid with bus_ack
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, timeout counter 0. Reset mid-access drops bus_req immediately.
//    A late bus_ack after reset is ignored.
//  FSM states: IDLE, BUSY, DONE.
//  IDLE:
//    - op = memread|memwrite. memwrite wins if both are set: treated as a store, read ignored.
//    - Aligned op: stall=1 combinationally in the same cycle; latch addr/be/we/wdata; go to BUSY.
//    - Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no bus access, misalign=1 next cycle, stall=0, rdata unchanged.
//  BUSY:
//    - bus_req=1 with address, be and data stable; stall=1.
//    - On bus_ack: capture load data into rdata; go to DONE.
//    - On TIMEOUT cycles without ack: err pulse, rdata=0 (loads only), go to DONE.
//  DONE:
//    - bus_req=0, stall=0 for exactly one cycle so the pipeline advances past the op; then go to IDLE.
//    - Guarantees the same op is never re-issued.
//  Latency: min 3 cycles op-to-advance (IDLE, BUSY with same-cycle ack, DONE); each wait cycle adds 1.
//  Byte enables:
//    - byte: 4'b0001<<addr[1:0]
//    - half: addr[1] ? 1100 : 0011
//    - word: 1111
//  bus_wdata: byte={4{wdata[7:0]}}, half={2{wdata[15:0]}}, word=wdata.
//  Load extract: select lane by addr[1:0]; extend to 32 bits per sign.
//  rdata holds its value until the next completed load or timeout; stores never modify it.
//  Timeout counter clears on entry to BUSY and saturates at TIMEOUT.
// TESTING
//  1. Word load addr=0x010, ack after 2 cycles, bus_rdata=0xDEADBEEF
//     -> bus_be=1111, stall high 3 cycles, rdata=0xDEADBEEF.
//  2. Byte load addr=0x013, sign=1, bus_rdata=0x80xxxxxx -> bus_be=1000, rdata=0xFFFFFF80.
//     Same access with sign=0 -> rdata=0x00000080.
//  3. Half store addr=0x006, wdata=0x0000ABCD
//     -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD, bus_addr=0x004.
//  4. Word load addr=0x012 -> misalign pulse, bus_req never rises, stall=0, rdata unchanged.
//  5. Load with no ack -> after 15 BUSY cycles err pulse, rdata=0, stall drops after DONE.
//  6. rst_n low while BUSY -> bus_req=0 immediately; ack 1 cycle after release ignored; FSM IDLE.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store responder behind the EX/MEM register: runs one req/ack access per op,
// stalls the pipeline while it is in flight, and returns lane-extracted, extended load data.
module lsu_mem_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [1:0]        length,
  input  logic              sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              misalign,
  output logic              err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic [1:0]          lane_reg;
  logic [1:0]          len_reg;
  logic                sign_reg;
  logic                load_reg;
  logic                we_reg;
  logic [3:0]          be_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   rdata_reg;
  logic                misalign_reg;
  logic                err_reg;
  logic [CNT_W-1:0]    cnt_reg;

  logic                op;
  logic                misaligned;
  logic [3:0]          be_calc;
  logic [DATA_W-1:0]   wdata_calc;
  logic [DATA_W-1:0]   shifted;
  logic [DATA_W-1:0]   load_ext;
  logic                start;
  logic                mis_det;
  logic                ack_hit;
  logic                tmo_hit;

  assign op = memread | memwrite;

  always_comb begin
    misaligned = 1'b0;
    be_calc    = 4'b1111;
    wdata_calc = wdata;
    case (length)
      2'b00: begin
        be_calc    = 4'b0001 << addr[1:0];
        wdata_calc = {4{wdata[7:0]}};
      end
      2'b01: begin
        misaligned = addr[0];
        be_calc    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{wdata[15:0]}};
      end
      default: begin
        misaligned = (addr[1:0] != 2'b00);
      end
    endcase
  end

  // Lane select by shifting the addressed byte down to bit 0, then extend.
  always_comb begin
    shifted  = bus_rdata >> {lane_reg, 3'b000};
    load_ext = bus_rdata;
    case (len_reg)
      2'b00:   load_ext = {{24{sign_reg & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{sign_reg & shifted[15]}}, shifted[15:0]};
      default: load_ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    start      = 1'b0;
    mis_det    = 1'b0;
    ack_hit    = 1'b0;
    tmo_hit    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (op) begin
          if (misaligned) begin
            mis_det = 1'b1;
          end else begin
            stall      = 1'b1;
            start      = 1'b1;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (bus_ack) begin
          ack_hit    = 1'b1;
          state_next = DONE;
        end else if (cnt_reg >= CNT_W'(TIMEOUT - 1)) begin
          tmo_hit    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      lane_reg     <= '0;
      len_reg      <= '0;
      sign_reg     <= 1'b0;
      load_reg     <= 1'b0;
      we_reg       <= 1'b0;
      be_reg       <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      misalign_reg <= 1'b0;
      err_reg      <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      misalign_reg <= mis_det;
      err_reg      <= tmo_hit;
      if (start) begin
        addr_reg  <= {addr[ADDR_W-1:2], 2'b00};
        lane_reg  <= addr[1:0];
        len_reg   <= length;
        sign_reg  <= sign;
        load_reg  <= memread & ~memwrite;
        we_reg    <= memwrite;
        be_reg    <= be_calc;
        wdata_reg <= wdata_calc;
        cnt_reg   <= '0;
      end else if (state_reg == BUSY && cnt_reg < CNT_W'(TIMEOUT)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (ack_hit && load_reg) begin
        rdata_reg <= load_ext;
      end else if (tmo_hit && load_reg) begin
        rdata_reg <= '0;
      end
    end
  end

  assign bus_req   = (state_reg == BUSY);
  assign bus_we    = we_reg;
  assign bus_addr  = addr_reg;
  assign bus_be    = be_reg;
  assign bus_wdata = wdata_reg;
  assign rdata     = rdata_reg;
  assign misalign  = misalign_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed vector table, reset-mid-access sequence, then
// randomized ops checked against a byte-lane reference model.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memread, memwrite, sign;
  logic [1:0]  length;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall, misalign, err;
  logic        bus_req, bus_we;
  logic [11:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .memread(memread), .memwrite(memwrite), .length(length), .sign(sign),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .misalign(misalign), .err(err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  len;
    logic        sg;
    logic [11:0] a;
    logic [31:0] wd;
    logic [31:0] brd;
    int          wt;     // wait cycles before ack; -1 = never ack
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [31:0] erd;
    logic        emis;
    int          estall;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] len,
                              input logic sg, input logic [11:0] a, input logic [31:0] wd,
                              input logic [31:0] brd, input int wt);
    vec_t v;
    v.rd = rd; v.wr = wr; v.len = len; v.sg = sg; v.a = a; v.wd = wd; v.brd = brd; v.wt = wt;
    v.ebe = '0; v.ewd = '0; v.erd = '0; v.emis = 1'b0; v.estall = 0;
    return v;
  endfunction

  // Reference model: reasons in bytes and lanes, not in RTL terms.
  function automatic vec_t model(input vec_t v, input logic [31:0] rprev);
    int n, lane;
    logic [31:0] val, mask;
    n    = (v.len == 2'b00) ? 1 : (v.len == 2'b01) ? 2 : 4;
    lane = int'(v.a) % 4;
    v.emis = ((int'(v.a) % n) != 0);
    v.ebe = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= lane && i < lane + n) v.ebe[i] = 1'b1;
      v.ewd[8*i +: 8] = v.wd[8*(i % n) +: 8];
    end
    v.erd = rprev;
    if (!v.emis && v.rd && !v.wr) begin
      if (v.wt < 0) begin
        v.erd = '0;
      end else begin
        val = v.brd >> (8 * lane);
        if (n < 4) begin
          mask = (32'd1 << (8 * n)) - 32'd1;
          val  = val & mask;
          if (v.sg && val[8*n-1]) val = val | ~mask;
        end
        v.erd = val;
      end
    end
    v.estall = v.emis ? 0 : (v.wt < 0 ? 16 : 2 + v.wt);
    return v;
  endfunction

  // Issue one op (called just after a rising edge) and check everything it produced.
  task automatic run_check(input string tag, input vec_t v);
    int  stall_cyc = 0, req_cnt = 0, guard = 0;
    bit  done = 0, saw_req = 0, mis = 0, er = 0;
    logic [3:0]  be = '0;
    logic [31:0] bwd = '0;
    logic [11:0] badr = '0;
    logic        we = 1'b0;
    memread = v.rd; memwrite = v.wr; length = v.len; sign = v.sg; addr = v.a; wdata = v.wd;
    while (!done && guard < 40) begin
      @(negedge clk);
      guard++;
      if (stall) stall_cyc++; else done = 1;
      if (misalign) mis = 1;
      if (err) er = 1;
      if (bus_req) begin
        saw_req = 1; be = bus_be; bwd = bus_wdata; badr = bus_addr; we = bus_we;
        if (req_cnt == v.wt) begin
          bus_ack = 1'b1;
          bus_rdata = v.brd;
        end
        req_cnt++;
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
      bus_rdata = $urandom;
    end
    memread = 1'b0; memwrite = 1'b0;
    @(negedge clk);
    if (misalign) mis = 1;
    if (err) er = 1;
    chk({tag, " completes"}, 32'(done), 32'd1);
    chk({tag, " stall_cycles"}, stall_cyc, v.estall);
    chk({tag, " bus_req_seen"}, 32'(saw_req), 32'(!v.emis));
    chk({tag, " misalign"}, 32'(mis), 32'(v.emis));
    chk({tag, " err"}, 32'(er), 32'(!v.emis && v.wt < 0));
    if (saw_req) begin
      chk({tag, " bus_be"}, 32'(be), 32'(v.ebe));
      chk({tag, " bus_wdata"}, bwd, v.ewd);
      chk({tag, " bus_addr"}, 32'(badr), 32'(v.a & 12'hFFC));
      chk({tag, " bus_we"}, 32'(we), 32'(v.wr));
    end
    chk({tag, " rdata"}, rdata, v.erd);
    $display("%s rd=%0b wr=%0b len=%0d sg=%0b addr=%h wt=%0d stall=%0d be=%h rdata=%h mis=%0b err=%0b",
             tag, v.rd, v.wr, v.len, v.sg, v.a, v.wt, stall_cyc, be, rdata, mis, er);
    @(posedge clk); #1;
  endtask

  vec_t tbl[9];
  vec_t rv;
  logic [31:0] rmodel;

  initial begin
    rst_n = 1'b0; memread = 0; memwrite = 0; length = 0; sign = 0; addr = 0; wdata = 0;
    bus_ack = 0; bus_rdata = 0;

    // Directed table with hand-derived expectations.
    tbl[0] = mk(1,0,2'b10,0,12'h010,32'h0,32'hDEADBEEF,1);
    tbl[0].ebe = 4'hF; tbl[0].ewd = 32'h0; tbl[0].erd = 32'hDEADBEEF; tbl[0].estall = 3;
    tbl[1] = mk(1,0,2'b00,1,12'h013,32'h0,32'h80123456,0);
    tbl[1].ebe = 4'h8; tbl[1].erd = 32'hFFFFFF80; tbl[1].estall = 2;
    tbl[2] = mk(1,0,2'b00,0,12'h013,32'h0,32'h80123456,0);
    tbl[2].ebe = 4'h8; tbl[2].erd = 32'h00000080; tbl[2].estall = 2;
    tbl[3] = mk(0,1,2'b01,0,12'h006,32'h0000ABCD,32'h0,2);
    tbl[3].ebe = 4'hC; tbl[3].ewd = 32'hABCDABCD; tbl[3].erd = 32'h00000080; tbl[3].estall = 4;
    tbl[4] = mk(1,0,2'b10,0,12'h012,32'h0,32'h0,0);
    tbl[4].emis = 1; tbl[4].erd = 32'h00000080; tbl[4].estall = 0;
    tbl[5] = mk(1,0,2'b10,0,12'h020,32'h0,32'h0,-1);
    tbl[5].ebe = 4'hF; tbl[5].erd = 32'h0; tbl[5].estall = 16;
    tbl[6] = mk(1,0,2'b01,1,12'h00A,32'h0,32'h80015555,0);
    tbl[6].ebe = 4'hC; tbl[6].erd = 32'hFFFF8001; tbl[6].estall = 2;
    tbl[7] = mk(1,1,2'b10,0,12'h024,32'h12345678,32'hCAFEF00D,0);
    tbl[7].ebe = 4'hF; tbl[7].ewd = 32'h12345678; tbl[7].erd = 32'hFFFF8001; tbl[7].estall = 2;
    tbl[8] = mk(0,1,2'b01,0,12'h005,32'h1111,32'h0,0);
    tbl[8].emis = 1; tbl[8].erd = 32'hFFFF8001; tbl[8].estall = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset rdata", rdata, 32'h0);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset bus_req", 32'(bus_req), 32'd0);
    chk("reset bus_be", 32'(bus_be), 32'd0);
    chk("reset misalign_err", 32'({misalign, err}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_check($sformatf("dir%0d", i), tbl[i]);

    // Reset while BUSY: bus_req drops at once, late ack is ignored.
    memread = 1; length = 2'b10; addr = 12'h040;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid busy bus_req", 32'(bus_req), 32'd1);
    #2;
    memread = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid bus_req drop", 32'(bus_req), 32'd0);
    chk("rst_mid stall drop", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    chk("rst_mid late ack bus_req", 32'(bus_req), 32'd0);
    chk("rst_mid late ack stall", 32'(stall), 32'd0);
    chk("rst_mid late ack rdata", rdata, 32'h0);
    chk("rst_mid late ack err", 32'(err), 32'd0);
    $display("rst_mid reset during BUSY, late ack rdata=%h bus_req=%0b", rdata, bus_req);
    @(posedge clk); #1;

    rmodel = 32'h0;
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 2);
      rv = mk(k != 1, k != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              12'($urandom), $urandom, $urandom,
              ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3)));
      rv = model(rv, rmodel);
      rmodel = rv.erd;
      run_check($sformatf("rnd%0d", i), rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
